// File: rtl/track_ctrl_pkg.sv
// track_ctrl_pkg
// Shared definitions for the train traffic controller and its track signal
// stage: track count, grant code constants, signal FSM state encoding and
// the grant decoder.
package track_ctrl_pkg;

    localparam int NUM_TRACKS = 4;

    // Grant codes driven by the upstream controller.
    localparam logic [2:0] GRANT_NONE = 3'd0;
    localparam logic [2:0] GRANT_T1   = 3'd1;
    localparam logic [2:0] GRANT_T2   = 3'd2;
    localparam logic [2:0] GRANT_T3   = 3'd3;
    localparam logic [2:0] GRANT_T4   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_POINT = 3'd1,
        ST_PROCEED   = 3'd2,
        ST_CLEARING  = 3'd3,
        ST_FAULT     = 3'd4
    } sig_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } track_sel_t;

    // Codes 1..4 map to tracks 0..3; 0 and 5..7 mean "no track".
    function automatic track_sel_t grant_to_track(input logic [2:0] code);
        track_sel_t r;
        r.valid = (code != GRANT_NONE) && (code <= GRANT_T4);
        r.idx   = 2'(code - GRANT_T1);
        return r;
    endfunction

endpackage

// File: rtl/track_exit_debounce.sv
// track_exit_debounce
// Consecutive-sample debouncer for the four exit sensors. Each track keeps a
// run counter of consecutive high samples that clears on any low sample.
// exit[i] is asserted combinationally on the sample that completes a run of
// DEBOUNCE highs (and on every further high sample of the same run).
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, clears all counters
//   sensor - raw exit detectors, one per track
//   exit   - debounced exit indication, one per track
module track_exit_debounce
    import track_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_TRACKS-1:0] sensor,
    output logic [NUM_TRACKS-1:0] exit
);

    // Counter only needs to reach DEBOUNCE-1; the current sample supplies
    // the final count.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt [NUM_TRACKS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TRACKS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
                if (!sensor[i])            cnt[i] <= '0;
                else if (cnt[i] != CNT_TOP) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        exit = '0;
        for (int i = 0; i < NUM_TRACKS; i++) exit[i] = sensor[i] && (cnt[i] == CNT_TOP);
    end

endmodule

// File: rtl/track_signal_controller.sv
// track_signal_controller
// Drives the point motor and per-track signal aspects for the track granted
// by the traffic controller, and returns a one-cycle train_done pulse once
// the occupying train has exited and the clearing delay has elapsed.
//
// Optional feature macro: TRACK_SIGNAL_YELLOW_EN
//   defined   - signal_yellow[trk] is lit throughout CLEARING
//   undefined - signal_yellow is tied to zero
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-high reset
//   grant         - track code (0 none, 1..4 tracks 0..3, 5..7 none)
//   exit_sensor   - raw exit detectors, per track
//   point_locked  - point motor reports locked position
//   point_sel     - track index the points are driven toward
//   point_move    - point motor drive enable
//   signal_green  - one-hot proceed aspect (zero = all red)
//   signal_yellow - caution aspect
//   train_done    - one-cycle completion pulse
//   fault         - point-lock timeout flag
//   state_dbg     - current FSM state, for observation
//
// Handshake: grant is a level held by the controller for the whole
// occupancy; train_done is a single-cycle pulse, after which the controller
// withdraws or changes grant. A grant change outside CLEARING aborts without
// a done pulse.
module track_signal_controller
    import track_ctrl_pkg::*;
#(
    parameter int POINT_TIMEOUT = 20,
    parameter int CLEAR_DELAY   = 3,
    parameter int DEBOUNCE      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            grant,
    input  logic [NUM_TRACKS-1:0] exit_sensor,
    input  logic                  point_locked,
    output logic [1:0]            point_sel,
    output logic                  point_move,
    output logic [NUM_TRACKS-1:0] signal_green,
    output logic [NUM_TRACKS-1:0] signal_yellow,
    output logic                  train_done,
    output logic                  fault,
    output sig_state_t            state_dbg
);

    localparam int MAX_T = (POINT_TIMEOUT > CLEAR_DELAY) ? POINT_TIMEOUT : CLEAR_DELAY;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam logic [TW-1:0] T_POINT = TW'(POINT_TIMEOUT - 1);
    localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_DELAY - 1);

    sig_state_t            state;
    logic [1:0]            trk;
    logic [2:0]            code;
    logic [TW-1:0]         timer;
    logic [NUM_TRACKS-1:0] exit_vec;
    track_sel_t            gsel;

    assign gsel      = grant_to_track(grant);
    assign point_sel = trk;
    assign state_dbg = state;

    track_exit_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .sensor (exit_sensor),
        .exit   (exit_vec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            trk          <= '0;
            code         <= GRANT_NONE;
            timer        <= '0;
            point_move   <= 1'b0;
            signal_green <= '0;
            train_done   <= 1'b0;
            fault        <= 1'b0;
`ifdef TRACK_SIGNAL_YELLOW_EN
            signal_yellow <= '0;
`endif
        end else begin
            train_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    point_move   <= 1'b0;
                    signal_green <= '0;
                    fault        <= 1'b0;
                    if (gsel.valid) begin
                        trk        <= gsel.idx;
                        code       <= grant;
                        timer      <= '0;
                        point_move <= 1'b1;
                        state      <= ST_SET_POINT;
                    end
                end
                ST_SET_POINT: begin
                    if (point_locked) begin
                        point_move   <= 1'b0;
                        signal_green <= 4'b0001 << trk;
                        state        <= ST_PROCEED;
                    end else if (grant != code) begin
                        point_move <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (timer == T_POINT) begin
                        point_move <= 1'b0;
                        fault      <= 1'b1;
                        state      <= ST_FAULT;
                    end else if (timer != {TW{1'b1}}) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_PROCEED: begin
                    if (exit_vec[trk]) begin
                        signal_green <= '0;
                        timer        <= '0;
`ifdef TRACK_SIGNAL_YELLOW_EN
                        signal_yellow <= 4'b0001 << trk;
`endif
                        state        <= ST_CLEARING;
                    end else if (grant != code) begin
                        signal_green <= '0;
                        state        <= ST_IDLE;
                    end
                end
                ST_CLEARING: begin
                    // Grant is deliberately ignored here: the train is leaving.
                    if (timer == T_CLEAR) begin
                        train_done <= 1'b1;
`ifdef TRACK_SIGNAL_YELLOW_EN
                        signal_yellow <= '0;
`endif
                        state      <= ST_IDLE;
                    end else if (timer != {TW{1'b1}}) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (!gsel.valid) begin
                        fault <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    point_move   <= 1'b0;
                    signal_green <= '0;
                    fault        <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef TRACK_SIGNAL_YELLOW_EN
    assign signal_yellow = '0;
`endif

endmodule

// File: tb/tb_track_signal_controller.sv
// tb_track_signal_controller
// Directed bench for track_signal_controller with default parameters
// (POINT_TIMEOUT 20, CLEAR_DELAY 3, DEBOUNCE 2). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point.
module tb_track_signal_controller;
  import track_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] grant;
  logic [3:0] exit_sensor;
  logic       point_locked;
  logic [1:0] point_sel;
  logic       point_move;
  logic [3:0] signal_green;
  logic [3:0] signal_yellow;
  logic       train_done;
  logic       fault;
  sig_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  track_signal_controller dut (
    .clk           (clk),
    .reset         (reset),
    .grant         (grant),
    .exit_sensor   (exit_sensor),
    .point_locked  (point_locked),
    .point_sel     (point_sel),
    .point_move    (point_move),
    .signal_green  (signal_green),
    .signal_yellow (signal_yellow),
    .train_done    (train_done),
    .fault         (fault),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Yellow is only lit when the optional caution aspect is built in.
  function automatic logic [3:0] yel(input logic [3:0] y);
`ifdef TRACK_SIGNAL_YELLOW_EN
    return y;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk_all(input string tag, input sig_state_t st, input logic [1:0] sel,
                         input logic mv, input logic [3:0] grn, input logic [3:0] y,
                         input logic dn, input logic flt);
    chk({tag, ".state"},  {5'd0, state_dbg}, {5'd0, st});
    chk({tag, ".sel"},    {6'd0, point_sel}, {6'd0, sel});
    chk({tag, ".move"},   {7'd0, point_move}, {7'd0, mv});
    chk({tag, ".green"},  {4'd0, signal_green}, {4'd0, grn});
    chk({tag, ".yellow"}, {4'd0, signal_yellow}, {4'd0, yel(y)});
    chk({tag, ".done"},   {7'd0, train_done}, {7'd0, dn});
    chk({tag, ".fault"},  {7'd0, fault}, {7'd0, flt});
  endtask

  initial begin
    reset = 1'b1;
    grant = 3'd0;
    exit_sensor = 4'b0000;
    point_locked = 1'b0;
    repeat (2) step();
    chk_all("reset", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_all("idle", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // grant track 1, lock three cycles later
    grant = 3'd2;
    step();
    chk_all("grant2", ST_SET_POINT, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    chk_all("wait_lock", ST_SET_POINT, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    point_locked = 1'b1;
    step();
    chk_all("locked", ST_PROCEED, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    point_locked = 1'b0;

    // one-cycle glitch on the own sensor, then a foreign sensor held high
    exit_sensor = 4'b0010;
    step();
    exit_sensor = 4'b0000;
    step();
    chk_all("glitch", ST_PROCEED, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    exit_sensor = 4'b0100;
    repeat (3) step();
    chk_all("other_trk", ST_PROCEED, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    exit_sensor = 4'b0000;
    step();

    // real exit: two high samples
    exit_sensor = 4'b0010;
    step();
    chk_all("exit_1st", ST_PROCEED, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("clear0", ST_CLEARING, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
    exit_sensor = 4'b0000;
    grant = 3'd0;
    step();
    chk_all("clear1", ST_CLEARING, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
    step();
    chk_all("clear2", ST_CLEARING, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
    step();
    chk_all("done", ST_IDLE, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    chk_all("done_once", ST_IDLE, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // point lock timeout on track 2
    grant = 3'd3;
    step();
    chk_all("to_entry", ST_SET_POINT, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      step();
      chk({"to_wait", ".fault"}, {7'd0, fault}, 8'd0);
    end
    chk_all("to_last", ST_SET_POINT, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("to_fault", ST_FAULT, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("fault_hold", ST_FAULT, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    grant = 3'd0;
    step();
    chk_all("fault_clr", ST_IDLE, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // lock arriving on the timeout cycle wins; then grant withdrawn in PROCEED
    grant = 3'd1;
    step();
    repeat (19) step();
    point_locked = 1'b1;
    step();
    chk_all("lock_vs_to", ST_PROCEED, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
    point_locked = 1'b0;
    grant = 3'd0;
    step();
    chk_all("abort_proc", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("abort_nodone", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // grant change together with lock: lock wins, abort follows next cycle
    grant = 3'd4;
    step();
    chk_all("grant4", ST_SET_POINT, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    grant = 3'd0;
    point_locked = 1'b1;
    step();
    chk_all("lock_vs_chg", ST_PROCEED, 2'd3, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0);
    point_locked = 1'b0;
    step();
    chk_all("chg_after", ST_IDLE, 2'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // abort in SET_POINT via an out-of-range code
    grant = 3'd3;
    step();
    grant = 3'd5;
    step();
    chk_all("abort_setpt", ST_IDLE, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    grant = 3'd0;
    step();

    // exit together with grant change: exit wins; then reset during CLEARING
    grant = 3'd2;
    step();
    point_locked = 1'b1;
    step();
    point_locked = 1'b0;
    exit_sensor = 4'b0010;
    step();
    grant = 3'd0;
    step();
    chk_all("exit_vs_chg", ST_CLEARING, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
    exit_sensor = 4'b0000;
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("async_rst", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk({"post_rst", ".done"}, {7'd0, train_done}, 8'd0);
    end
    chk_all("post_rst_end", ST_IDLE, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
